hilo_muldiv_ctrl: RTL and testbench

Owns the HI/LO architectural registers and sequences the fixed-latency pipelined unsigned divider for DIV/DIVU. Sits in the EX stage beside the ALU. It takes multiply results combinationally from the ALU, converts signed divide operands to magnitudes, and holds the pipeline with a stall until the quotient and remainder are sign-corrected and committed. It also performs MTHI/MTLO writes and aborts cleanly on an exception flush.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/hilo_regs.sv | 23 ++
 rtl/hilo_muldiv_ctrl.sv | 112 +++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
// Op codes match the decoder; 0 and 7 are no-ops.
package muldiv_pkg;

    localparam int DIV_LAT_DEF = 33;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Two's-complement magnitude for signed operands, pass-through otherwise.
    function automatic logic [31:0] operand_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair with independent write enables.
module hilo_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic [31:0] hi_d,
    input  logic        lo_we,
    input  logic [31:0] lo_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage HI/LO owner: commits multiplies and MTHI/MTLO, sequences the
// fixed-latency unsigned divider and sign-corrects its results.
//   state  | meaning
//   IDLE   | accepting requests; non-divide ops complete in one cycle
//   RUN    | divider enabled, counter running, pipeline held
//   COMMIT | sign-corrected q/s written to LO/HI, pipeline released
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] mul_lo,
    input  logic [31:0] mul_hi,
    output logic        div_ena,
    output logic [31:0] div_z,
    output logic [31:0] div_d,
    input  logic [31:0] div_q,
    input  logic [31:0] div_s,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               sq;
    logic               sr;

    logic               accept;
    logic               op_mul;
    logic               op_div;
    logic               op_signed;
    logic               start;
    logic               commit;
    logic               hi_we;
    logic               lo_we;
    logic [31:0]        hi_d;
    logic [31:0]        lo_d;

    assign accept    = (state == ST_IDLE) && req_valid && !flush;
    assign op_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign op_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
    assign op_signed = (req_op == OP_DIV);
    // Divide by zero leaves HI/LO untouched and never wakes the divider.
    assign start     = accept && op_div && (y != 32'd0);
    assign commit    = (state == ST_COMMIT) && !flush;

    assign div_ena   = (state == ST_RUN) && !flush;
    assign stall     = start || div_ena;
    assign busy      = (state != ST_IDLE);

    assign hi_we = commit || (accept && (op_mul || req_op == OP_MTHI));
    assign lo_we = commit || (accept && (op_mul || req_op == OP_MTLO));
    assign hi_d  = commit ? (sr ? (32'd0 - div_s) : div_s)
                          : ((req_op == OP_MTHI) ? x : mul_hi);
    assign lo_d  = commit ? (sq ? (32'd0 - div_q) : div_q)
                          : ((req_op == OP_MTLO) ? y : mul_lo);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            div_z <= '0;
            div_d <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        div_z <= operand_mag(x, op_signed);
                        div_d <= operand_mag(y, op_signed);
                        sq    <= op_signed && (x[31] ^ y[31]);
                        sr    <= op_signed && x[31];
                        cnt   <= CNT_W'(DIV_LAT - 1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == '0) state <= ST_COMMIT;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    hilo_regs u_hilo_regs (
        .clk   (clk),
        .rst   (rst),
        .hi_we (hi_we),
        .hi_d  (hi_d),
        .lo_we (lo_we),
        .lo_d  (lo_d),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: a vector table, directed flush/reset sequences
// and random ops checked against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] x = '0, y = '0, mul_lo = '0, mul_hi = '0;
    logic        div_ena, stall, busy;
    logic [31:0] div_z, div_d, div_q, div_s, hi, lo;

    hilo_muldiv_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
        .x(x), .y(y), .mul_lo(mul_lo), .mul_hi(mul_hi),
        .div_ena(div_ena), .div_z(div_z), .div_d(div_d), .div_q(div_q), .div_s(div_s),
        .stall(stall), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Divider model: results are only valid after exactly DIV_LAT enabled cycles.
    int          ena_cnt = 0;
    int          ena_total = 0;
    int          unstable = 0;
    logic [31:0] cap_z = '0, cap_d = '0;
    always @(posedge clk) begin
        if (div_ena) begin
            if (ena_cnt == 0) begin
                cap_z <= div_z;
                cap_d <= div_d;
            end else if (div_z != cap_z || div_d != cap_d) begin
                unstable <= unstable + 1;
            end
            ena_cnt   <= ena_cnt + 1;
            ena_total <= ena_total + 1;
        end else begin
            ena_cnt <= 0;
        end
    end
    assign div_q = (ena_cnt == DIV_LAT && cap_d != 0) ? cap_z / cap_d : 32'hDEAD_BEEF;
    assign div_s = (ena_cnt == DIV_LAT && cap_d != 0) ? cap_z % cap_d : 32'hBAAD_F00D;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference HI/LO behaviour from plain arithmetic.
    logic [31:0] m_hi = '0, m_lo = '0;
    task automatic ref_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] mh, input logic [31:0] ml, output int st);
        longint sa, sb, q, r;
        st = 0;
        case (op)
            3'd1, 3'd2: begin m_hi = mh; m_lo = ml; end
            3'd5: m_hi = a;
            3'd6: m_lo = b;
            3'd3: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0]; st = DIV_LAT + 1;
            end
            3'd4: if (b != 0) begin
                m_lo = a / b; m_hi = a % b; st = DIV_LAT + 1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
        return (sgn && $signed(v) < 0) ? 32'(-$signed(v)) : v;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] mh, input logic [31:0] ml);
        req_valid = 1'b1; req_op = op; x = a; y = b; mul_hi = mh; mul_lo = ml;
    endtask

    // Issue one op, hold it while stalled, then check HI/LO and handshake.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] mh, input logic [31:0] ml,
                         input logic [31:0] ehi, input logic [31:0] elo, input int est);
        int ns, e0, u0;
        @(negedge clk);
        e0 = ena_total; u0 = unstable;
        drive(op, a, b, mh, ml);
        #1;
        ns = 0;
        while (stall && ns < 100) begin
            ns++;
            @(negedge clk); #1;
        end
        if (ns >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: stall still high after %0d cycles", tag, ns);
        end
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0;
        #1;
        chk({tag, " stall_cycles"}, 32'(ns), 32'(est));
        chk({tag, " ena_cycles"}, 32'(ena_total - e0), (est != 0) ? 32'(DIV_LAT) : 32'd0);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        if (est != 0) begin
            chk({tag, " div_z"}, cap_z, mag(a, op == 3'd3));
            chk({tag, " div_d"}, cap_d, mag(b, op == 3'd3));
            chk({tag, " zd_stable"}, 32'(unstable - u0), 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, mh, ml, ehi, elo;
        int          est;
    } vec_t;
    vec_t tbl[11];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] mh, input logic [31:0] ml,
                                input logic [31:0] ehi, input logic [31:0] elo, input int est);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.mh = mh; v.ml = ml; v.ehi = ehi; v.elo = elo; v.est = est;
        return v;
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb, rmh, rml;
        logic [63:0] prod;
        int          rst_exp;

        tbl[0]  = mk(3'd5, 32'h11, 0, 0, 0, 32'h11, 32'h0, 0);
        tbl[1]  = mk(3'd6, 0, 32'h22, 0, 0, 32'h11, 32'h22, 0);
        tbl[2]  = mk(3'd3, 32'd5, 32'd0, 0, 0, 32'h11, 32'h22, 0);
        tbl[3]  = mk(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        tbl[4]  = mk(3'd4, 32'hFFFF_FFFF, 32'h10, 0, 0, 32'h0000_000F, 32'h0FFF_FFFF, 34);
        tbl[5]  = mk(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h8000_0000, 34);
        tbl[6]  = mk(3'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        tbl[7]  = mk(3'd7, 32'h55, 32'h66, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        tbl[8]  = mk(3'd3, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'h1, 32'hFFFF_FFFD, 34);
        tbl[9]  = mk(3'd4, 32'd9, 32'd4, 0, 0, 32'h1, 32'h2, 34);
        tbl[10] = mk(3'd0, 32'h77, 32'h88, 32'h3, 32'h4, 32'h1, 32'h2, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset stall", {31'd0, stall}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset div_ena", {31'd0, div_ena}, 0);
        chk("reset div_z", div_z, 0);
        chk("reset div_d", div_d, 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].mh, tbl[i].ml,
                  tbl[i].ehi, tbl[i].elo, tbl[i].est);
        m_hi = 32'h1; m_lo = 32'h2;

        // MULT then MTHI on consecutive cycles.
        @(negedge clk);
        drive(3'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        #1 chk("mult stall", {31'd0, stall}, 0);
        @(negedge clk);
        drive(3'd5, 32'h1234, 0, 0, 0);
        #1;
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFFA);
        chk("mthi stall", {31'd0, stall}, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mthi hi", hi, 32'h1234);
        chk("mthi lo", lo, 32'hFFFF_FFFA);
        m_hi = 32'h1234; m_lo = 32'hFFFF_FFFA;

        // Flush at RUN cycle 10, then a fresh DIVU.
        @(negedge clk);
        drive(3'd3, 32'd100, 32'd3, 0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_run stall", {31'd0, stall}, 0);
        chk("flush_run div_ena", {31'd0, div_ena}, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("flush_run busy", {31'd0, busy}, 0);
        chk("flush_run hi", hi, m_hi);
        chk("flush_run lo", lo, m_lo);
        do_op("post_flush", 3'd4, 32'd9, 32'd4, 0, 0, 32'd1, 32'd2, 34);
        m_hi = 32'd1; m_lo = 32'd2;

        // Flush during COMMIT suppresses the write.
        @(negedge clk);
        drive(3'd3, 32'd100, 32'd3, 0, 0);
        #1;
        for (int k = 0; k < 100 && stall; k++) begin
            @(negedge clk); #1;
        end
        chk("commit busy", {31'd0, busy}, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("flush_commit hi", hi, m_hi);
        chk("flush_commit lo", lo, m_lo);
        chk("flush_commit busy", {31'd0, busy}, 0);

        // Flush in the accept cycle blocks the accept.
        @(negedge clk);
        drive(3'd3, 32'd100, 32'd3, 0, 0);
        flush = 1'b1;
        #1 chk("flush_accept stall", {31'd0, stall}, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1 chk("flush_accept busy", {31'd0, busy}, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (rop == 3'd1) prod = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            else             prod = {32'd0, ra} * {32'd0, rb};
            rmh = prod[63:32]; rml = prod[31:0];
            ref_step(rop, ra, rb, rmh, rml, rst_exp);
            do_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, rmh, rml, m_hi, m_lo, rst_exp);
        end

        // Reset at RUN cycle 5.
        @(negedge clk);
        drive(3'd4, 32'd1000, 32'd7, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rst_run hi", hi, 0);
        chk("rst_run lo", lo, 0);
        chk("rst_run stall", {31'd0, stall}, 0);
        chk("rst_run div_ena", {31'd0, div_ena}, 0);
        chk("rst_run busy", {31'd0, busy}, 0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
